// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS main control FSM.
// States, opcodes, ALU op codes and the control vector bundle.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDIEX  = 4'd8,
    S_ORIEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_BEQ     = 4'd11,
    S_BNE     = 4'd12,
    S_JUMP    = 4'd13,
    S_ILLEGAL = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       zeroextend;
    logic       branch;
    logic       branchne;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;
  } ctrl_t;

  function automatic state_t decode_op(input logic [5:0] op);
    state_t s;
    case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = S_EXEC;
      OP_BEQ:       s = S_BEQ;
      OP_BNE:       s = S_BNE;
      OP_ADDI:      s = S_ADDIEX;
      OP_ORI:       s = S_ORIEX;
      OP_J:         s = S_JUMP;
      default:      s = S_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared instruction/data memory port handshake.
// The controller is master; the memory answers with mem_ready.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic iord;
  logic memwrite;

  modport master (
    output mem_req,
    output iord,
    output memwrite,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  iord,
    input  memwrite,
    output mem_ready
  );
endinterface

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Pure state -> control vector decode for the multicycle FSM.
// Unknown encodings decode to an all-zero vector.
module mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Moore decode of every datapath enable and select
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: ctrl.alusrcb = 2'b11;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALU_ADD;
      end
      S_ORIEX: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = 2'b10;
        ctrl.aluop      = ALU_OR;
        ctrl.zeroextend = 1'b1;
      end
      S_IMMWB: ctrl.regwrite = 1'b1;
      S_BEQ: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      S_BNE: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALU_SUB;
        ctrl.pcsrc    = 2'b01;
        ctrl.branchne = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      S_ILLEGAL: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Holds state, next-state logic, reset gating and pcen.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [5:0]             op,
  input  logic                   zero,
  mips_multicycle_ctrl_if.master mem,
  output logic                   irwrite,
  output logic                   pcwrite,
  output logic                   pcen,
  output logic [1:0]             pcsrc,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic [1:0]             aluop,
  output logic                   zeroextend,
  output logic                   branch,
  output logic                   branchne,
  output logic                   regdst,
  output logic                   memtoreg,
  output logic                   regwrite,
  output logic                   illegal_op,
  output logic [3:0]             state_dbg
);

  state_t state_q, state_d;
  logic   is_lw_q, is_lw_d;
  ctrl_t  dec;
  ctrl_t  gated;

  mc_outdec u_outdec (
    .state (state_q),
    .ctrl  (dec)
  );

  // Next state; the LW/SW choice is latched in decode so op is
  // never looked at again for the rest of the instruction
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    case (state_q)
      S_FETCH:
        if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = decode_op(op);
        is_lw_d = (op == OP_LW);
      end
      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        if (mem.mem_ready) state_d = S_MEMWB;
      S_MEMWR:
        if (mem.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_IMMWB;
      S_ORIEX:  state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  // Fetch strobes wait for memory; reset forces everything low
  always_comb begin
    gated = dec;
    if (state_q == S_FETCH && !mem.mem_ready) begin
      gated.irwrite = 1'b0;
      gated.pcwrite = 1'b0;
    end
    if (!reset_n) gated = '0;
  end

  assign mem.mem_req  = gated.mem_req;
  assign mem.iord     = gated.iord;
  assign mem.memwrite = gated.memwrite;
  assign irwrite      = gated.irwrite;
  assign pcwrite      = gated.pcwrite;
  assign pcsrc        = gated.pcsrc;
  assign alusrca      = gated.alusrca;
  assign alusrcb      = gated.alusrcb;
  assign aluop        = gated.aluop;
  assign zeroextend   = gated.zeroextend;
  assign branch       = gated.branch;
  assign branchne     = gated.branchne;
  assign regdst       = gated.regdst;
  assign memtoreg     = gated.memtoreg;
  assign regwrite     = gated.regwrite;
  assign illegal_op   = gated.illegal_op;
  assign state_dbg    = state_q;

  assign pcen = gated.pcwrite
              | (gated.branch & zero)
              | (gated.branchne & ~zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction step model,
// table of instruction summaries, corner sequences, random run.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       zeroextend;
    logic       branch;
    logic       branchne;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;
  } cv_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         cyc;
    int         nrw;
    int         npc;
    int         nmw;
    int         nil;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       irwrite, pcwrite, pcen, alusrca;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       zeroextend, branch, branchne;
  logic       regdst, memtoreg, regwrite, illegal_op;
  logic [3:0] state_dbg;
  cv_t        act;
  int         nvec;
  int         nbad;

  mips_multicycle_ctrl_if mbus ();

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .zero       (zero),
    .mem        (mbus),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .pcen       (pcen),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .zeroextend (zeroextend),
    .branch     (branch),
    .branchne   (branchne),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {mbus.mem_req, mbus.iord, mbus.memwrite,
                irwrite, pcwrite, pcen, pcsrc, alusrca,
                alusrcb, aluop, zeroextend, branch, branchne,
                regdst, memtoreg, regwrite, illegal_op};

  function automatic int ilen(input logic [5:0] o);
    if (o == LW) return 5;
    if (o == SW || o == RT || o == ADDI || o == ORI) return 4;
    return 3;
  endfunction

  function automatic bit waits(input logic [5:0] o, input int s);
    return (s == 0) || (s == 3 && (o == LW || o == SW));
  endfunction

  // Expected controls for step s of an instruction with opcode o
  function automatic cv_t exp_cv(input logic [5:0] o, input int s,
                                 input logic z, input logic r);
    cv_t e;
    e = '0;
    if (s == 0) begin
      e.mem_req = 1'b1;
      e.alusrcb = 2'b01;
      e.irwrite = r;
      e.pcwrite = r;
      e.pcen    = r;
    end else if (s == 1) begin
      e.alusrcb = 2'b11;
    end else begin
      case (o)
        LW, SW: begin
          if (s == 2) begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
          end else if (s == 3) begin
            e.mem_req  = 1'b1;
            e.iord     = 1'b1;
            e.memwrite = (o == SW);
          end else begin
            e.memtoreg = 1'b1;
            e.regwrite = 1'b1;
          end
        end
        RT: begin
          if (s == 2) begin
            e.alusrca = 1'b1;
            e.aluop   = 2'b10;
          end else begin
            e.regdst   = 1'b1;
            e.regwrite = 1'b1;
          end
        end
        ADDI, ORI: begin
          if (s == 2) begin
            e.alusrca    = 1'b1;
            e.alusrcb    = 2'b10;
            e.aluop      = (o == ORI) ? 2'b11 : 2'b00;
            e.zeroextend = (o == ORI);
          end else begin
            e.regwrite = 1'b1;
          end
        end
        BEQ, BNE: begin
          e.alusrca  = 1'b1;
          e.aluop    = 2'b01;
          e.pcsrc    = 2'b01;
          e.branch   = (o == BEQ);
          e.branchne = (o == BNE);
          e.pcen     = (o == BEQ) ? z : ~z;
        end
        JMP: begin
          e.pcsrc   = 2'b10;
          e.pcwrite = 1'b1;
          e.pcen    = 1'b1;
        end
        default: e.illegal_op = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic tick(output cv_t a);
    @(negedge clk);
    a = act;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input cv_t e, input string nm);
    cv_t a;
    tick(a);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s op=%b: got %h want %h", nm, op, a, e);
    end
  endtask

  vec_t tv [11];

  initial begin
    cv_t a;
    int  rw, pc, mw, il;
    logic [5:0] ops [9];

    nvec = 0;
    nbad = 0;
    reset_n = 1'b0;
    op = '0;
    zero = 1'b0;
    mbus.mem_ready = 1'b0;

    tv[0]  = '{LW,   1'b0, 5, 1, 1, 0, 0};
    tv[1]  = '{SW,   1'b0, 4, 0, 1, 1, 0};
    tv[2]  = '{RT,   1'b1, 4, 1, 1, 0, 0};
    tv[3]  = '{ADDI, 1'b0, 4, 1, 1, 0, 0};
    tv[4]  = '{ORI,  1'b1, 4, 1, 1, 0, 0};
    tv[5]  = '{BEQ,  1'b1, 3, 0, 2, 0, 0};
    tv[6]  = '{BEQ,  1'b0, 3, 0, 1, 0, 0};
    tv[7]  = '{BNE,  1'b1, 3, 0, 1, 0, 0};
    tv[8]  = '{BNE,  1'b0, 3, 0, 2, 0, 0};
    tv[9]  = '{JMP,  1'b0, 3, 0, 2, 0, 0};
    tv[10] = '{BAD,  1'b0, 3, 0, 1, 0, 1};

    @(posedge clk);
    #1;
    mbus.mem_ready = 1'b1;
    chk('0, "reset_hold");
    reset_n = 1'b1;
    mbus.mem_ready = 1'b0;
    chk(exp_cv(RT, 0, 1'b0, 1'b0), "fetch_stall");

    for (int i = 0; i < 11; i++) begin
      op = tv[i].op;
      zero = tv[i].z;
      mbus.mem_ready = 1'b1;
      rw = 0; pc = 0; mw = 0; il = 0;
      for (int c = 0; c < tv[i].cyc; c++) begin
        tick(a);
        rw += int'(a.regwrite);
        pc += int'(a.pcen);
        mw += int'(a.memwrite);
        il += int'(a.illegal_op);
      end
      nvec++;
      if (rw != tv[i].nrw || pc != tv[i].npc ||
          mw != tv[i].nmw || il != tv[i].nil) begin
        nbad++;
        $display("FAIL table%0d counts rw/pc/mw/il: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 i, rw, pc, mw, il,
                 tv[i].nrw, tv[i].npc, tv[i].nmw, tv[i].nil);
      end
      mbus.mem_ready = 1'b0;
      chk(exp_cv(tv[i].op, 0, tv[i].z, 1'b0), "table_refetch");
    end

    // SW with three stall cycles in the write
    op = SW;
    zero = 1'b0;
    mbus.mem_ready = 1'b1;
    chk(exp_cv(SW, 0, 1'b0, 1'b1), "sw_fetch");
    chk(exp_cv(SW, 1, 1'b0, 1'b1), "sw_decode");
    op = RT;
    chk(exp_cv(SW, 2, 1'b0, 1'b1), "sw_adr");
    mbus.mem_ready = 1'b0;
    repeat (3) chk(exp_cv(SW, 3, 1'b0, 1'b0), "sw_stall");
    mbus.mem_ready = 1'b1;
    chk(exp_cv(SW, 3, 1'b0, 1'b1), "sw_done");
    mbus.mem_ready = 1'b0;
    chk(exp_cv(SW, 0, 1'b0, 1'b0), "sw_next_fetch");

    // LW stalled in the read, op changed after decode, then reset
    op = LW;
    mbus.mem_ready = 1'b1;
    chk(exp_cv(LW, 0, 1'b0, 1'b1), "lw_fetch");
    chk(exp_cv(LW, 1, 1'b0, 1'b1), "lw_decode");
    op = SW;
    chk(exp_cv(LW, 2, 1'b0, 1'b1), "lw_adr");
    mbus.mem_ready = 1'b0;
    repeat (2) chk(exp_cv(LW, 3, 1'b0, 1'b0), "lw_rd_stall");
    reset_n = 1'b0;
    mbus.mem_ready = 1'b1;
    chk('0, "rst_mid");
    reset_n = 1'b1;
    mbus.mem_ready = 1'b0;
    chk(exp_cv(LW, 0, 1'b0, 1'b0), "rst_fetch");

    ops = '{LW, SW, RT, BEQ, BNE, ADDI, ORI, JMP, BAD};
    for (int n = 0; n < 150; n++) begin
      logic [5:0] io;
      int s, stall;
      logic r;
      int k;
      k = int'($urandom_range(0, 9));
      io = (k == 9) ? 6'($urandom) : ops[k];
      s = 0;
      stall = 0;
      while (s < ilen(io)) begin
        op = (s == 1) ? io : 6'($urandom);
        zero = 1'($urandom);
        if (waits(io, s))
          r = (stall >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
        else
          r = 1'($urandom);
        mbus.mem_ready = r;
        chk(exp_cv(io, s, zero, r), "rand");
        if (!waits(io, s) || r) begin
          s++;
          stall = 0;
        end else begin
          stall++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
